dp_keyword_detector: RTL and testbench

//  Left-to-right dynamic-programming (Viterbi-style) keyword matcher behind the DNN stage.
//  Per frame it consumes TMPSIZE signed template-state scores serially and updates a cumulative path score per state.

---
 rtl/dp_pkg.sv | 46 ++++
 rtl/dp_score_mem.sv | 51 +++++
 rtl/dp_keyword_detector.sv | 123 ++++++++++++
 tb/tb_dp_keyword_detector.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// ============================================================================
//  Module      : dp_pkg
//  Description : Shared types and arithmetic helpers for the DP keyword
//                detector. Scores are carried in a fixed 32-bit working type
//                and clamped to the accumulator width passed in by the caller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dp_pkg;

  // Default signed accumulator width; must hold the detection threshold.
  localparam int ACCW = 24;

  // Working width for intermediate arithmetic (accumulator width must be < WIDE).
  localparam int WIDE = 32;

  typedef logic signed [WIDE-1:0] wide_t;

  // Signed add of a and b, saturated to the signed range of a w-bit number.
  // Inputs are assumed already within that range (or small penalties), so a
  // single guard bit is enough to catch overflow.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    logic signed [WIDE:0] sum;
    logic signed [WIDE:0] one;
    logic signed [WIDE:0] hi;
    logic signed [WIDE:0] lo;
    one = {{WIDE{1'b0}}, 1'b1};
    sum = {a[WIDE-1], a} + {b[WIDE-1], b};
    hi  = (one <<< (w - 1)) - one;
    lo  = ~hi;                        // -2^(w-1) in two's complement
    if (sum > hi) begin
      return hi[WIDE-1:0];
    end else if (sum < lo) begin
      return lo[WIDE-1:0];
    end
    return sum[WIDE-1:0];
  endfunction

  function automatic wide_t smax(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dp_score_mem.sv
// ============================================================================
//  Module      : dp_score_mem
//  Description : DEPTH x WIDTH cumulative-score storage. Asynchronous read and
//                synchronous write at one shared address, plus a single-cycle
//                clear of every entry (clear wins over a same-cycle write).
//  Ports       : clk     in   clock, rising edge
//                reset   in   asynchronous active-high reset, zeroes storage
//                addr    in   read/write index
//                rd_data out  entry at addr (combinational)
//                wr_en   in   write wr_data to addr on this edge
//                wr_data in   value to write
//                clr     in   zero all entries on this edge
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_score_mem #(
  parameter int DEPTH = 35,
  parameter int WIDTH = 24,
  parameter int AW    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           addr,
  output logic signed [WIDTH-1:0] rd_data,
  input  logic                    wr_en,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    clr
);

  logic signed [WIDTH-1:0] d [DEPTH];

  assign rd_data = d[addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else if (wr_en) begin
      d[addr] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dp_keyword_detector.sv
// ============================================================================
//  Module      : dp_keyword_detector
//  Description : Left-to-right Viterbi-style keyword matcher. Each frame brings
//                TMPSIZE serial signed state scores; the cumulative path score
//                of every template state is updated in place and a detection
//                is flagged when the final state reaches DETECTED.
//  Ports       : clk       in   clock, rising edge
//                reset     in   asynchronous active-high reset
//                vec_in    in   signed score of the current state index
//                dv_in     in   one-cycle strobe, vec_in valid
//                vad_in    in   voice activity, sampled with state 0
//                result_dv out  one-cycle strobe, result/vad_out valid
//                result    out  1 = keyword detected in this frame
//                vad_out   out  voice activity of the reported frame
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_keyword_detector
  import dp_pkg::*;
#(
  parameter int BIT      = 11,
  parameter int HPENALTY = 0,
  parameter int VPENALTY = 0,
  parameter int DETECTED = 65536,
  parameter int TMPSIZE  = 35,
  parameter int ACCW     = dp_pkg::ACCW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [BIT-1:0] vec_in,
  input  logic           dv_in,
  input  logic           vad_in,
  output logic           result_dv,
  output logic           result,
  output logic           vad_out
);

  localparam int            IW       = (TMPSIZE > 1) ? $clog2(TMPSIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TMPSIZE - 1);

  logic [IW-1:0]          idx;
  logic signed [ACCW-1:0] prev;        // old D[idx-1], captured before overwrite
  logic signed [ACCW-1:0] rd_data;
  logic signed [ACCW-1:0] wr_data;
  logic                   vad_lat;
  logic                   s1_dv;
  logic                   s1_det;
  logic                   s1_vad;

  wide_t score_w, cur_w, prev_w, stay_w, adv_w, upd_w;
  logic  is_first, is_last, frame_vad, hit, clr;

  dp_score_mem #(
    .DEPTH (TMPSIZE),
    .WIDTH (ACCW),
    .AW    (IW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .addr    (idx),
    .rd_data (rd_data),
    .wr_en   (dv_in),
    .wr_data (wr_data),
    .clr     (clr)
  );

  // Recurrence datapath for the element at idx.
  always_comb begin
    is_first  = (idx == '0);
    is_last   = (idx == LAST_IDX);
    score_w   = {{(WIDE-BIT){vec_in[BIT-1]}}, vec_in};
    cur_w     = {{(WIDE-ACCW){rd_data[ACCW-1]}}, rd_data};
    prev_w    = {{(WIDE-ACCW){prev[ACCW-1]}}, prev};
    stay_w    = sat_add(cur_w, wide_t'(-HPENALTY), ACCW);
    // State 0 may be entered fresh on any frame: its "advance" source is 0.
    adv_w     = is_first ? '0 : sat_add(prev_w, wide_t'(-VPENALTY), ACCW);
    upd_w     = sat_add(score_w, smax(stay_w, adv_w), ACCW);
    wr_data   = upd_w[ACCW-1:0];
    hit       = (upd_w >= wide_t'(DETECTED));
    // With a single-state template the vad sample and frame end coincide.
    frame_vad = is_first ? vad_in : vad_lat;
    // Clearing on the final element's edge means the next frame's state 0
    // always reads zeroed scores, even when it follows immediately.
    clr       = dv_in & is_last & (hit | ~frame_vad);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      prev      <= '0;
      vad_lat   <= 1'b0;
      s1_dv     <= 1'b0;
      s1_det    <= 1'b0;
      s1_vad    <= 1'b0;
      result_dv <= 1'b0;
      result    <= 1'b0;
      vad_out   <= 1'b0;
    end else begin
      s1_dv <= 1'b0;
      if (dv_in) begin
        prev <= rd_data;
        idx  <= is_last ? '0 : idx + 1'b1;
        if (is_first) begin
          vad_lat <= vad_in;
        end
        if (is_last) begin
          s1_dv  <= 1'b1;
          s1_det <= hit;
          s1_vad <= frame_vad;
        end
      end
      result_dv <= s1_dv;
      if (s1_dv) begin
        result  <= s1_det;
        vad_out <= s1_vad;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dp_keyword_detector.sv
// ============================================================================
//  Module      : tb_dp_keyword_detector
//  Description : Directed self-checking bench. Two detectors share stimulus:
//                dut0 with zero penalties, dut1 with both penalties = 100.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dp_keyword_detector;

  localparam int TMP = 35;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [10:0] vec;
  logic               dv;
  logic               vad;
  logic               rdv0, res0, vo0;
  logic               rdv1, res1, vo1;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int q0_res[$];
  int q0_vad[$];
  int q0_cyc[$];
  int q1_res[$];

  dp_keyword_detector dut0 (
    .clk(clk), .reset(reset), .vec_in(vec), .dv_in(dv), .vad_in(vad),
    .result_dv(rdv0), .result(res0), .vad_out(vo0)
  );

  dp_keyword_detector #(.HPENALTY(100), .VPENALTY(100)) dut1 (
    .clk(clk), .reset(reset), .vec_in(vec), .dv_in(dv), .vad_in(vad),
    .result_dv(rdv1), .result(res1), .vad_out(vo1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdv0 === 1'b1) begin
      q0_res.push_back(int'(res0));
      q0_vad.push_back(int'(vo0));
      q0_cyc.push_back(cyc);
    end
    if (rdv1 === 1'b1) q1_res.push_back(int'(res1));
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    dv = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({rdv0, res0, vo0} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset got=%b exp=000", {rdv0, res0, vo0});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q0_res.delete(); q0_vad.delete(); q0_cyc.delete(); q1_res.delete();
  endtask

  // Drive one element for a single cycle; c is the cycle it was driven in.
  task automatic send(input logic signed [10:0] s, input int gap, output int c);
    dv = 1'b1;
    vec = s;
    c = cyc;
    @(posedge clk); #1;
    dv = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic run_frame(input logic signed [10:0] s, input logic v, input int gap,
                           output int last_c);
    int c;
    vad = v;
    for (int i = 0; i < TMP; i++) send(s, gap, c);
    last_c = c;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; dv = 1'b0; vec = '0; vad = 1'b0;
    #2;
    checks++;
    if ({rdv0, res0, vo0, rdv1, res1, vo1} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000", {rdv0, res0, vo0, rdv1, res1, vo1});
    end
    checks++;
    if (int'(dut0.u_mem.d[0]) !== 0 || int'(dut0.u_mem.d[34]) !== 0) begin
      failures++;
      $display("FAIL reset_scores got=%0d,%0d exp=0,0",
               int'(dut0.u_mem.d[0]), int'(dut0.u_mem.d[34]));
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q0_res.size() !== 0 || rdv0 !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_result got=%0d exp=0", q0_res.size());
    end
  endtask

  // Frames of 1023: D[j] = 1023*f, detection at frame 65, then scores clear.
  task automatic test_accumulate();
    int lc;
    apply_reset();
    for (int f = 1; f <= 65; f++) run_frame(11'sd1023, 1'b1, 0, lc);
    drain();
    checks++;
    if (q0_res.size() !== 65) begin
      failures++;
      $display("FAIL acc_count got=%0d exp=65", q0_res.size());
    end else begin
      for (int f = 1; f <= 65; f++) begin
        checks++;
        if (q0_res[f-1] !== ((f == 65) ? 1 : 0) || q0_vad[f-1] !== 1) begin
          failures++;
          $display("FAIL acc_frame%0d got=res%0d/vad%0d exp=res%0d/vad1",
                   f, q0_res[f-1], q0_vad[f-1], (f == 65) ? 1 : 0);
        end
      end
      checks++;
      if (q0_cyc[64] !== lc + 2) begin
        failures++;
        $display("FAIL acc_latency got=%0d exp=%0d", q0_cyc[64], lc + 2);
      end
    end
    checks++;
    if (int'(dut0.u_mem.d[0]) !== 0 || int'(dut0.u_mem.d[34]) !== 0) begin
      failures++;
      $display("FAIL acc_cleared got=%0d,%0d exp=0,0",
               int'(dut0.u_mem.d[0]), int'(dut0.u_mem.d[34]));
    end
    checks++;
    if (res0 !== 1'b1 || rdv0 !== 1'b0) begin
      failures++;
      $display("FAIL acc_hold got=res%b/dv%b exp=res1/dv0", res0, rdv0);
    end
    run_frame(11'sd1023, 1'b1, 0, lc);
    drain();
    checks++;
    if (int'(dut0.u_mem.d[34]) !== 1023 || q0_res.size() !== 66 || res0 !== 1'b0) begin
      failures++;
      $display("FAIL acc_restart got=d34 %0d n%0d res%b exp=d34 1023 n66 res0",
               int'(dut0.u_mem.d[34]), q0_res.size(), res0);
    end
  endtask

  // All -1024: D[j] settles at -1024*(j+1); never detects, never wraps.
  task automatic test_negative();
    int lc;
    int bad;
    apply_reset();
    for (int f = 1; f <= 100; f++) run_frame(-11'sd1024, 1'b1, 0, lc);
    drain();
    bad = 0;
    for (int i = 0; i < q0_res.size(); i++) if (q0_res[i] !== 0) bad++;
    checks++;
    if (q0_res.size() !== 100 || bad !== 0) begin
      failures++;
      $display("FAIL neg_results got=n%0d hits%0d exp=n100 hits0", q0_res.size(), bad);
    end
    checks++;
    if (int'(dut0.u_mem.d[0]) !== -1024) begin
      failures++;
      $display("FAIL neg_d0 got=%0d exp=-1024", int'(dut0.u_mem.d[0]));
    end
    checks++;
    if (int'(dut0.u_mem.d[1]) !== -2048 || int'(dut0.u_mem.d[34]) !== -35840) begin
      failures++;
      $display("FAIL neg_d1_d34 got=%0d,%0d exp=-2048,-35840",
               int'(dut0.u_mem.d[1]), int'(dut0.u_mem.d[34]));
    end
  endtask

  // Silence in frame 40 clears scores; 65 more frames needed -> frame 105.
  task automatic test_vad_silence();
    int lc;
    apply_reset();
    for (int f = 1; f <= 105; f++) begin
      run_frame(11'sd1023, (f != 40), 0, lc);
      if (f == 40) begin
        checks++;
        if (int'(dut0.u_mem.d[0]) !== 0 || int'(dut0.u_mem.d[34]) !== 0) begin
          failures++;
          $display("FAIL vad_clear got=%0d,%0d exp=0,0",
                   int'(dut0.u_mem.d[0]), int'(dut0.u_mem.d[34]));
        end
      end
    end
    drain();
    checks++;
    if (q0_res.size() !== 105) begin
      failures++;
      $display("FAIL vad_count got=%0d exp=105", q0_res.size());
    end else begin
      for (int f = 1; f <= 105; f++) begin
        checks++;
        if (q0_res[f-1] !== ((f == 105) ? 1 : 0) || q0_vad[f-1] !== ((f == 40) ? 0 : 1)) begin
          failures++;
          $display("FAIL vad_frame%0d got=res%0d/vad%0d exp=res%0d/vad%0d", f,
                   q0_res[f-1], q0_vad[f-1], (f == 105) ? 1 : 0, (f == 40) ? 0 : 1);
        end
      end
    end
  endtask

  // Penalties 100: state 0 is floored at 0 so its first frame keeps 1023;
  // D[34] = 923*f + 100 for f >= 35, first >= 65536 at f = 71 (65633).
  task automatic test_penalty();
    int lc;
    apply_reset();
    run_frame(11'sd1023, 1'b1, 0, lc);
    checks++;
    if (int'(dut1.u_mem.d[0]) !== 1023 || int'(dut1.u_mem.d[34]) !== 923) begin
      failures++;
      $display("FAIL pen_frame1 got=%0d,%0d exp=1023,923",
               int'(dut1.u_mem.d[0]), int'(dut1.u_mem.d[34]));
    end
    for (int f = 2; f <= 72; f++) run_frame(11'sd1023, 1'b1, 0, lc);
    drain();
    checks++;
    if (q1_res.size() !== 72) begin
      failures++;
      $display("FAIL pen_count got=%0d exp=72", q1_res.size());
    end else begin
      for (int f = 1; f <= 72; f++) begin
        checks++;
        if (q1_res[f-1] !== ((f == 71) ? 1 : 0)) begin
          failures++;
          $display("FAIL pen_frame%0d got=%0d exp=%0d", f, q1_res[f-1], (f == 71) ? 1 : 0);
        end
      end
    end
  endtask

  // Reset after 20 elements discards the partial frame.
  task automatic test_mid_reset();
    int lc;
    int c;
    apply_reset();
    vad = 1'b1;
    for (int i = 0; i < 20; i++) send(11'sd1023, 0, c);
    apply_reset();
    run_frame(11'sd1023, 1'b1, 0, lc);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (q0_res.size() !== 1) begin
      failures++;
      $display("FAIL midrst_count got=%0d exp=1", q0_res.size());
    end else begin
      checks++;
      if (q0_res[0] !== 0 || q0_cyc[0] !== lc + 2) begin
        failures++;
        $display("FAIL midrst_result got=res%0d cyc%0d exp=res0 cyc%0d",
                 q0_res[0], q0_cyc[0], lc + 2);
      end
    end
    checks++;
    if (int'(dut0.u_mem.d[0]) !== 1023 || int'(dut0.u_mem.d[20]) !== 1023 ||
        int'(dut0.u_mem.d[34]) !== 1023) begin
      failures++;
      $display("FAIL midrst_scores got=%0d,%0d,%0d exp=1023,1023,1023",
               int'(dut0.u_mem.d[0]), int'(dut0.u_mem.d[20]), int'(dut0.u_mem.d[34]));
    end
  endtask

  // 63 back-to-back frames, then frames 64/65 with one strobe per 312 cycles.
  task automatic test_back_to_back();
    int lc;
    int lc64;
    apply_reset();
    for (int f = 1; f <= 63; f++) run_frame(11'sd1023, 1'b1, 0, lc);
    run_frame(11'sd1023, 1'b1, 311, lc64);
    run_frame(11'sd1023, 1'b1, 311, lc);
    drain();
    checks++;
    if (q0_res.size() !== 65) begin
      failures++;
      $display("FAIL gap_count got=%0d exp=65", q0_res.size());
    end else begin
      checks++;
      if (q0_res[63] !== 0 || q0_res[64] !== 1) begin
        failures++;
        $display("FAIL gap_results got=%0d,%0d exp=0,1", q0_res[63], q0_res[64]);
      end
      checks++;
      if (q0_cyc[63] !== lc64 + 2 || q0_cyc[64] !== lc + 2) begin
        failures++;
        $display("FAIL gap_latency got=%0d,%0d exp=%0d,%0d",
                 q0_cyc[63], q0_cyc[64], lc64 + 2, lc + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_negative();
    test_vad_silence();
    test_penalty();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
